lpc_post_capture: RTL and testbench



---
 rtl/lpc_post_capture_pkg.sv | 25 ++
 rtl/lpc_post_capture_sync_fifo.sv | 63 ++++++
 rtl/lpc_post_capture.sv | 140 ++++++++++++++
 tb/tb_lpc_post_capture.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lpc_post_capture_pkg.sv
// Shared definitions for the LPC POST-code capture block: FSM encodings,
// default I/O addresses and the status byte layout.
package lpc_post_capture_pkg;

  typedef enum logic [1:0] {
    POST_ST_IDLE   = 2'd0,
    POST_ST_WR_ACK = 2'd1,
    POST_ST_RD_ACK = 2'd2
  } post_state_e;

  localparam logic [15:0] DEF_POST_ADDR = 16'h0080;
  localparam logic [15:0] DEF_STAT_ADDR = 16'h0081;
  localparam int          DEF_DEPTH     = 8;
  localparam logic [3:0]  DEF_IRQ       = 4'd1;
  localparam logic [7:0]  RD_UNMAPPED   = 8'hFF;

  // Status byte seen by the host: {ovf, full, empty, count[4:0]}
  function automatic logic [7:0] status_byte(input logic       ovf,
                                             input logic       full,
                                             input logic       empty,
                                             input logic [4:0] count);
    return {ovf, full, empty, count};
  endfunction

endpackage

// File: rtl/lpc_post_capture_sync_fifo.sv
// Show-ahead synchronous FIFO with flush; the head reads as zero while empty
// so the consumer-facing data bus has a defined value out of reset.
module lpc_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     nrst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // A full FIFO still accepts a push when the head leaves on the same edge
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem[wr_ptr_q] <= data_i;
  end

  assign data_o = empty_o ? '0 : mem[rd_ptr_q];

endmodule

// File: rtl/lpc_post_capture.sv
// POST-port capture behind the LPC peripheral: acknowledges I/O cycles, queues
// port-0x80 writes for a local consumer and serves last-code/status reads.
module lpc_post_capture
  import lpc_post_capture_pkg::*;
#(
  parameter logic [15:0] POST_ADDR = DEF_POST_ADDR,
  parameter logic [15:0] STAT_ADDR = DEF_STAT_ADDR,
  parameter int          DEPTH     = DEF_DEPTH,
  parameter logic [3:0]  IRQ       = DEF_IRQ
) (
  input  logic        clk_i,
  input  logic        nrst_i,
  input  logic [15:0] lpc_addr_i,
  input  logic [7:0]  lpc_wdata_i,
  input  logic        lpc_data_wr_i,
  output logic        lpc_wr_done_o,
  input  logic        lpc_data_req_i,
  output logic [7:0]  lpc_rdata_o,
  output logic        lpc_data_rd_o,
  output logic [3:0]  irq_num_o,
  output logic        interrupt_o,
  output logic        post_valid_o,
  output logic [7:0]  post_data_o,
  input  logic        post_ready_i
);

  localparam int CW = $clog2(DEPTH) + 1;

  post_state_e state_q, state_d;
  logic        wr_q, req_q;
  logic        wr_start, rd_start;
  logic        wr_accept, rd_accept;
  logic        is_post, is_stat;
  logic [7:0]  last_code_q;
  logic [7:0]  rdata_q;
  logic [7:0]  rdata_d;
  logic        ovf_q;
  logic        irq_q;
  logic        ovf_set, ovf_clr;

  logic          fifo_push, fifo_pop, fifo_flush;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [7:0]    fifo_head;
  logic [4:0]    count5;

  assign wr_start = lpc_data_wr_i & ~wr_q;
  assign rd_start = lpc_data_req_i & ~req_q;
  assign is_post  = (lpc_addr_i == POST_ADDR);
  assign is_stat  = (lpc_addr_i == STAT_ADDR);

  always_comb begin
    state_d   = state_q;
    wr_accept = 1'b0;
    rd_accept = 1'b0;
    case (state_q)
      POST_ST_IDLE: begin
        if (wr_start) begin
          state_d   = POST_ST_WR_ACK;
          wr_accept = 1'b1;
        end else if (rd_start) begin
          state_d   = POST_ST_RD_ACK;
          rd_accept = 1'b1;
        end
      end
      // Strobe dropping early (host abort) lands here too
      POST_ST_WR_ACK: if (!lpc_data_wr_i)  state_d = POST_ST_IDLE;
      POST_ST_RD_ACK: if (!lpc_data_req_i) state_d = POST_ST_IDLE;
      default:        state_d = POST_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q <= POST_ST_IDLE;
      wr_q    <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= lpc_data_wr_i;
      req_q   <= lpc_data_req_i;
    end
  end

  assign lpc_wr_done_o = (state_q == POST_ST_WR_ACK);
  assign lpc_data_rd_o = (state_q == POST_ST_RD_ACK);

  // Write decode happens only on the edge entering WR_ACK
  assign fifo_push  = wr_accept & is_post;
  assign fifo_pop   = post_ready_i & ~fifo_empty;
  assign fifo_flush = wr_accept & is_stat & lpc_wdata_i[0];
  assign ovf_set    = fifo_push & fifo_full & ~fifo_pop;
  assign ovf_clr    = (wr_accept & is_stat & lpc_wdata_i[1]) | (rd_accept & is_stat);

  lpc_sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .nrst_i  (nrst_i),
    .push_i  (fifo_push),
    .data_i  (lpc_wdata_i),
    .pop_i   (fifo_pop),
    .flush_i (fifo_flush),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign count5 = 5'(fifo_count);

  always_comb begin
    rdata_d = RD_UNMAPPED;
    if (is_post)      rdata_d = last_code_q;
    else if (is_stat) rdata_d = status_byte(ovf_q, fifo_full, fifo_empty, count5);
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      last_code_q <= 8'h00;
      rdata_q     <= RD_UNMAPPED;
      ovf_q       <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      if (fifo_push) last_code_q <= lpc_wdata_i;
      if (rd_accept) rdata_q     <= rdata_d;
      if (ovf_set)      ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
      irq_q <= ovf_q;
    end
  end

  assign lpc_rdata_o  = rdata_q;
  assign interrupt_o  = irq_q;
  assign irq_num_o    = IRQ;
  assign post_valid_o = ~fifo_empty;
  assign post_data_o  = fifo_head;

endmodule

// File: tb/tb_lpc_post_capture.sv
// Bench for lpc_post_capture: directed vector table, corner sequences and a
// random phase, all compared cycle by cycle against a queue-based model.
module tb_lpc_post_capture;

  localparam int DEPTH = 8;

  logic        clk_i = 1'b0;
  logic        nrst_i;
  logic [15:0] lpc_addr_i;
  logic [7:0]  lpc_wdata_i;
  logic        lpc_data_wr_i;
  logic        lpc_wr_done_o;
  logic        lpc_data_req_i;
  logic [7:0]  lpc_rdata_o;
  logic        lpc_data_rd_o;
  logic [3:0]  irq_num_o;
  logic        interrupt_o;
  logic        post_valid_o;
  logic [7:0]  post_data_o;
  logic        post_ready_i;

  lpc_post_capture #(.DEPTH(DEPTH)) dut (
    .clk_i          (clk_i),
    .nrst_i         (nrst_i),
    .lpc_addr_i     (lpc_addr_i),
    .lpc_wdata_i    (lpc_wdata_i),
    .lpc_data_wr_i  (lpc_data_wr_i),
    .lpc_wr_done_o  (lpc_wr_done_o),
    .lpc_data_req_i (lpc_data_req_i),
    .lpc_rdata_o    (lpc_rdata_o),
    .lpc_data_rd_o  (lpc_data_rd_o),
    .irq_num_o      (irq_num_o),
    .interrupt_o    (interrupt_o),
    .post_valid_o   (post_valid_o),
    .post_data_o    (post_data_o),
    .post_ready_i   (post_ready_i)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  // Reference model: host-visible state kept as plain variables and a queue
  logic [7:0] m_q[$];
  int         m_mode;          // 0 none, 1 write acknowledged, 2 read acknowledged
  logic [7:0] m_last, m_rdata;
  bit         m_ovf, m_irq, m_wrp, m_rqp;
  logic [7:0] drained[$];

  typedef struct {
    bit          is_wr;
    logic [15:0] addr;
    logic [7:0]  data;
    logic [7:0]  exp;
  } vec_t;
  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_mode = 0; m_last = 8'h00; m_rdata = 8'hFF;
    m_ovf = 0; m_irq = 0; m_wrp = 0; m_rqp = 0;
  endtask

  // One clock: predict from the inputs now applied, step, compare at negedge
  task automatic tick();
    bit pop, ws, rs, push, flush, nxt_irq;
    logic [7:0] st;
    pop   = post_ready_i && (m_q.size() > 0);
    ws    = lpc_data_wr_i && !m_wrp;
    rs    = lpc_data_req_i && !m_rqp;
    push  = 0;
    flush = 0;
    nxt_irq = m_ovf;
    st = {m_ovf, m_q.size() == DEPTH, m_q.size() == 0, 5'(m_q.size())};
    if (m_mode == 0 && ws) begin
      m_mode = 1;
      if (lpc_addr_i == 16'h0080) begin
        m_last = lpc_wdata_i;
        if (m_q.size() < DEPTH || pop) push = 1;
        else m_ovf = 1;
      end else if (lpc_addr_i == 16'h0081) begin
        if (lpc_wdata_i[0]) flush = 1;
        if (lpc_wdata_i[1]) m_ovf = 0;
      end
    end else if (m_mode == 0 && rs) begin
      m_mode = 2;
      if (lpc_addr_i == 16'h0080)      m_rdata = m_last;
      else if (lpc_addr_i == 16'h0081) begin m_rdata = st; m_ovf = 0; end
      else                             m_rdata = 8'hFF;
    end else if (m_mode == 1 && !lpc_data_wr_i) m_mode = 0;
    else if (m_mode == 2 && !lpc_data_req_i) m_mode = 0;
    if (flush) m_q.delete();
    else begin
      if (pop)  void'(m_q.pop_front());
      if (push) m_q.push_back(lpc_wdata_i);
    end
    m_irq = nxt_irq;
    m_wrp = lpc_data_wr_i;
    m_rqp = lpc_data_req_i;
    @(posedge clk_i);
    @(negedge clk_i);
    chk("wr_done", lpc_wr_done_o, 32'(m_mode == 1));
    chk("data_rd", lpc_data_rd_o, 32'(m_mode == 2));
    chk("rdata", lpc_rdata_o, m_rdata);
    chk("interrupt", interrupt_o, m_irq);
    chk("post_valid", post_valid_o, 32'(m_q.size() > 0));
    chk("post_data", post_data_o, (m_q.size() > 0) ? m_q[0] : 8'h00);
    chk("irq_num", irq_num_o, 4'd1);
  endtask

  task automatic io_write(input logic [15:0] a, input logic [7:0] d, input bit with_pop);
    lpc_addr_i = a; lpc_wdata_i = d; lpc_data_wr_i = 1'b1;
    if (with_pop) post_ready_i = 1'b1;
    tick();
    post_ready_i = 1'b0;
    tick();
    chk("wr_done_held", lpc_wr_done_o, 1);
    lpc_data_wr_i = 1'b0;
    tick();
    chk("wr_done_fall", lpc_wr_done_o, 0);
  endtask

  task automatic io_read(input logic [15:0] a, output logic [7:0] d);
    lpc_addr_i = a; lpc_data_req_i = 1'b1;
    tick();
    chk("rd_rise", lpc_data_rd_o, 1);
    d = lpc_rdata_o;
    tick();
    lpc_data_req_i = 1'b0;
    tick();
    chk("rd_fall", lpc_data_rd_o, 0);
  endtask

  task automatic drain();
    drained.delete();
    post_ready_i = 1'b1;
    for (int k = 0; k < 3 * DEPTH && post_valid_o; k++) begin
      drained.push_back(post_data_o);
      tick();
    end
    post_ready_i = 1'b0;
    chk("drain_done", post_valid_o, 0);
  endtask

  initial begin
    logic [7:0] r;
    nrst_i = 1'b0; lpc_addr_i = 16'h0; lpc_wdata_i = 8'h0;
    lpc_data_wr_i = 1'b0; lpc_data_req_i = 1'b0; post_ready_i = 1'b0;
    model_reset();
    repeat (3) @(negedge clk_i);
    chk("rst_wr_done", lpc_wr_done_o, 0);
    chk("rst_data_rd", lpc_data_rd_o, 0);
    chk("rst_rdata", lpc_rdata_o, 8'hFF);
    chk("rst_irq", interrupt_o, 0);
    chk("rst_valid", post_valid_o, 0);
    chk("rst_data", post_data_o, 8'h00);
    nrst_i = 1'b1;
    tick();

    vecs[0] = '{1, 16'h0080, 8'h55, 8'h00};
    vecs[1] = '{0, 16'h0080, 8'h00, 8'h55};
    vecs[2] = '{0, 16'h0081, 8'h00, 8'h01};
    vecs[3] = '{0, 16'h03F8, 8'h00, 8'hFF};
    vecs[4] = '{1, 16'h0081, 8'h01, 8'h00};
    vecs[5] = '{0, 16'h0081, 8'h00, 8'h20};
    vecs[6] = '{1, 16'h1234, 8'h77, 8'h00};
    vecs[7] = '{0, 16'h0080, 8'h00, 8'h55};
    vecs[8] = '{0, 16'h0081, 8'h00, 8'h20};
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].is_wr) io_write(vecs[i].addr, vecs[i].data, 0);
      else begin
        io_read(vecs[i].addr, r);
        chk($sformatf("vec%0d_rdata", i), r, vecs[i].exp);
      end
    end

    // Overflow: nine writes into an eight-deep FIFO
    for (int i = 1; i <= 9; i++) io_write(16'h0080, 8'(i), 0);
    chk("ovf_irq_set", interrupt_o, 1);
    io_read(16'h0081, r);
    chk("ovf_status", r, 8'hC8);
    chk("ovf_irq_clr", interrupt_o, 0);
    io_read(16'h0081, r);
    chk("ovf_status_reread", r, 8'h48);
    drain();
    chk("ovf_drain_cnt", drained.size(), 8);
    for (int i = 0; i < drained.size(); i++) chk($sformatf("ovf_drain%0d", i), drained[i], 8'(i + 1));

    // Push coinciding with a pop on a full FIFO
    for (int i = 0; i < DEPTH; i++) io_write(16'h0080, 8'h10 + 8'(i), 0);
    io_write(16'h0080, 8'hAA, 1);
    io_read(16'h0081, r);
    chk("pushpop_status", r, 8'h48);
    chk("pushpop_irq", interrupt_o, 0);
    drain();
    chk("pushpop_drain_cnt", drained.size(), 8);
    if (drained.size() == 8) chk("pushpop_last", drained[7], 8'hAA);

    // Flush with entries queued
    for (int i = 0; i < 3; i++) io_write(16'h0080, 8'hC0 + 8'(i), 0);
    io_write(16'h0081, 8'h01, 0);
    chk("flush_valid", post_valid_o, 0);
    io_read(16'h0081, r);
    chk("flush_status", r, 8'h20);

    // Write strobe aborted after one cycle
    lpc_addr_i = 16'h0080; lpc_wdata_i = 8'h99; lpc_data_wr_i = 1'b1;
    tick();
    lpc_data_wr_i = 1'b0;
    tick();
    chk("abort_idle", lpc_wr_done_o, 0);
    io_read(16'h0080, r);
    chk("abort_last_code", r, 8'h99);

    // Reset while a write is being acknowledged, strobe kept high
    drain();
    lpc_addr_i = 16'h0080; lpc_wdata_i = 8'h42; lpc_data_wr_i = 1'b1;
    tick();
    #2 nrst_i = 1'b0;
    #1;
    chk("mid_rst_wr_done", lpc_wr_done_o, 0);
    chk("mid_rst_rdata", lpc_rdata_o, 8'hFF);
    chk("mid_rst_valid", post_valid_o, 0);
    chk("mid_rst_data", post_data_o, 8'h00);
    chk("mid_rst_irq", interrupt_o, 0);
    model_reset();
    @(negedge clk_i);
    nrst_i = 1'b1;
    tick();
    chk("post_rst_wr_done", lpc_wr_done_o, 1);
    lpc_data_wr_i = 1'b0;
    tick();
    tick();

    // Random host traffic and consumer back-pressure
    for (int i = 0; i < 600; i++) begin
      if (lpc_data_wr_i) begin
        if ($urandom_range(0, 2) == 0) lpc_data_wr_i = 1'b0;
      end else if (lpc_data_req_i) begin
        if ($urandom_range(0, 2) == 0) lpc_data_req_i = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4, 5: lpc_addr_i = 16'h0080;
          6, 7:             lpc_addr_i = 16'h0081;
          default:          lpc_addr_i = 16'($urandom);
        endcase
        lpc_wdata_i = 8'($urandom);
        if (lpc_addr_i == 16'h0081)
          lpc_wdata_i = {lpc_wdata_i[7:2], ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0)};
        case ($urandom_range(0, 7))
          0:       begin lpc_data_wr_i = 1'b1; lpc_data_req_i = 1'b1; end
          1, 2, 3: lpc_data_req_i = 1'b1;
          default: lpc_data_wr_i = 1'b1;
        endcase
      end
      post_ready_i = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
